// File: rtl/rx_unstuff_shift.sv
// rx_unstuff_shift: receive-path bit unstuffer and LSB-first word assembler.
// Sits after the NRZI decoder. It drops the stuffed zero that follows a run
// of STUFF_RUN ones and packs the remaining data bits into DATA_W-bit words.
// It also keeps a sticky flag for stuffing violations. A violation is a one
// arriving in a stuff-bit slot.

module rx_unstuff_shift #(
  parameter int STUFF_RUN = 6,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              d_orig,
  input  logic              shift_enable,
  input  logic              clear,
  output logic [DATA_W-1:0] rx_byte,
  output logic              byte_ready,
  output logic              stuff_err
);

  // ones_cnt must reach STUFF_RUN itself. bit_cnt only ever holds 0..DATA_W-1.
  localparam int OW = $clog2(STUFF_RUN + 1);
  localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [OW-1:0] RUN_LIMIT = OW'(STUFF_RUN);
  localparam logic [OW-1:0] ONES_ONE  = OW'(1'b1);
  localparam logic [OW-1:0] ONES_ZERO = {OW{1'b0}};
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1'b1);
  localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};

  // State registers and their next-state values.
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic [OW-1:0]     ones_cnt_q, ones_cnt_d;
  logic [BW-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [DATA_W-1:0] rx_byte_q,  rx_byte_d;
  logic              ready_q,    ready_d;
  logic              err_q,      err_d;

  // Decoded view of the current strobe.
  logic              stuff_slot_s;
  logic              data_bit_s;
  logic              word_done_s;
  logic [DATA_W-1:0] shift_in_s;

  // Classify the incoming bit. It is either a stuff-bit slot or a data bit.
  // For a data bit, work out whether it completes a word.
  always_comb begin
    stuff_slot_s = 1'b0;
    data_bit_s   = 1'b0;
    word_done_s  = 1'b0;
    shift_in_s   = {d_orig, shift_q[DATA_W-1:1]};
    if (shift_enable && !clear) begin
      if (ones_cnt_q == RUN_LIMIT) begin
        stuff_slot_s = 1'b1;
      end else begin
        data_bit_s  = 1'b1;
        word_done_s = (bit_cnt_q == BIT_LAST);
      end
    end else begin
      stuff_slot_s = 1'b0;
      data_bit_s   = 1'b0;
    end
  end

  // Next-state logic. Priority is clear first, then a stuff slot, then a data bit.
  always_comb begin
    shift_d    = shift_q;
    ones_cnt_d = ones_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    rx_byte_d  = rx_byte_q;
    ready_d    = 1'b0;
    err_d      = err_q;
    if (clear) begin
      // Start of packet: drop any partial word, but rx_byte keeps its last value.
      shift_d    = {DATA_W{1'b0}};
      ones_cnt_d = ONES_ZERO;
      bit_cnt_d  = BIT_ZERO;
      err_d      = 1'b0;
    end else if (stuff_slot_s) begin
      // The stuffed bit is discarded. A one here breaks the stuffing rule.
      ones_cnt_d = ONES_ZERO;
      if (d_orig) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else if (data_bit_s) begin
      shift_d = shift_in_s;
      // The run count carries across word boundaries on purpose.
      if (d_orig) begin
        ones_cnt_d = ones_cnt_q + ONES_ONE;
      end else begin
        ones_cnt_d = ONES_ZERO;
      end
      if (word_done_s) begin
        bit_cnt_d = BIT_ZERO;
        rx_byte_d = shift_in_s;
        ready_d   = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_ONE;
      end
    end else begin
      // Idle cycle: everything holds.
      shift_d = shift_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      shift_q    <= {DATA_W{1'b0}};
      ones_cnt_q <= ONES_ZERO;
      bit_cnt_q  <= BIT_ZERO;
      rx_byte_q  <= {DATA_W{1'b0}};
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      ones_cnt_q <= ones_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_byte_q  <= rx_byte_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    rx_byte    = rx_byte_q;
    byte_ready = ready_q;
    stuff_err  = err_q;
  end

endmodule

// File: tb/tb_rx_unstuff_shift.sv
// Bench for rx_unstuff_shift. Directed bit sequences are driven in. Each
// expected word is queued before its bits are sent, and a monitor pops and
// compares it whenever byte_ready is seen. Flag and timing checks run inline.

module tb_rx_unstuff_shift;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_orig;
  logic       shift_enable;
  logic       clear;
  logic [7:0] rx_byte;
  logic       byte_ready;
  logic       stuff_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  rx_unstuff_shift #(.STUFF_RUN(6), .DATA_W(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .clear        (clear),
    .rx_byte      (rx_byte),
    .byte_ready   (byte_ready),
    .stuff_err    (stuff_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Each step starts and ends at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Optional idle gap, then one strobe. Returns just after the sampling edge.
  task automatic strobe(input logic b, input int gap);
    idle(gap);
    d_orig       = b;
    shift_enable = 1'b1;
    @(posedge clk);
    #1;
    shift_enable = 1'b0;
    d_orig       = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // Sends 0xA5 LSB first with idle gaps and checks the exact byte_ready timing.
  task automatic scenario_a5(input string tag);
    logic [7:0] v;
    v = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      strobe(v[i], 1);
      if (i == 6) check({tag, " ready low before 8th"}, {7'd0, byte_ready}, 8'h00);
      if (i == 7) check({tag, " ready after 8th"}, {7'd0, byte_ready}, 8'h01);
    end
    idle(1);
    check({tag, " ready one cycle"}, {7'd0, byte_ready}, 8'h00);
    check({tag, " stuff_err"}, {7'd0, stuff_err}, 8'h00);
  endtask

  initial begin
    logic [7:0] v;
    n_rst        = 1'b0;
    d_orig       = 1'b0;
    shift_enable = 1'b0;
    clear        = 1'b0;

    // Monitor: each byte_ready must match the next queued word.
    fork
      forever begin
        @(negedge clk);
        if (byte_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected byte_ready: rx_byte 0x%02h, none expected", rx_byte);
          end else begin
            check("rx_byte", rx_byte, exp_q.pop_front());
          end
        end
      end
    join_none

    // Reset state.
    idle(3);
    check("reset rx_byte", rx_byte, 8'h00);
    check("reset byte_ready", {7'd0, byte_ready}, 8'h00);
    check("reset stuff_err", {7'd0, stuff_err}, 8'h00);
    n_rst = 1'b1;
    idle(1);

    // Scenario 1: plain byte 0xA5.
    scenario_a5("s1");

    // Scenario 2: six ones, a stuffed zero, then two ones, giving 0xFF after 9 strobes.
    pulse_clear();
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 9; i++) begin
      strobe((i == 6) ? 1'b0 : 1'b1, 1);
      if (i == 7) check("s2 no ready after 8th", {7'd0, byte_ready}, 8'h00);
      if (i == 8) check("s2 ready after 9th", {7'd0, byte_ready}, 8'h01);
    end
    idle(2);
    check("s2 stuff_err", {7'd0, stuff_err}, 8'h00);

    // Scenario 5: partial word, clear with a strobe, then 0x3C.
    pulse_clear();
    strobe(1'b1, 1);
    strobe(1'b0, 1);
    strobe(1'b1, 1);
    strobe(1'b1, 1);
    d_orig       = 1'b1;
    shift_enable = 1'b1;
    clear        = 1'b1;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    shift_enable = 1'b0;
    d_orig       = 1'b0;
    check("s5 rx_byte held after clear", rx_byte, 8'hFF);
    exp_q.push_back(8'h3C);
    v = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      strobe(v[i], 1);
      if (i == 6) check("s5 rx_byte held at 7", rx_byte, 8'hFF);
      if (i == 7) check("s5 ready after 8th", {7'd0, byte_ready}, 8'h01);
    end
    idle(2);

    // Scenario 4: 0xFC back-to-back, a stuffed zero, then 8 zeros give 0x00.
    pulse_clear();
    exp_q.push_back(8'hFC);
    exp_q.push_back(8'h00);
    v = 8'hFC;
    for (int i = 0; i < 8; i++) strobe(v[i], 0);
    check("s4 ready after FC", {7'd0, byte_ready}, 8'h01);
    strobe(1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      strobe(1'b0, 0);
      if (i == 6) check("s4 no early ready", {7'd0, byte_ready}, 8'h00);
      if (i == 7) check("s4 ready after zeros", {7'd0, byte_ready}, 8'h01);
    end
    idle(2);

    // Scenario 3: seven ones. The 7th lands in a stuff slot and is a violation.
    pulse_clear();
    for (int i = 0; i < 7; i++) begin
      strobe(1'b1, 1);
      if (i == 5) check("s3 err low after 6th", {7'd0, stuff_err}, 8'h00);
      if (i == 6) check("s3 err after 7th", {7'd0, stuff_err}, 8'h01);
    end
    for (int i = 0; i < 20; i++) begin
      idle(1);
      check("s3 err sticky", {7'd0, stuff_err}, 8'h01);
    end
    // The 7th one was not data, so two zeros finish the word as 0x3F.
    exp_q.push_back(8'h3F);
    strobe(1'b0, 1);
    check("s3 no ready after 1 zero", {7'd0, byte_ready}, 8'h00);
    strobe(1'b0, 1);
    check("s3 ready after 2 zeros", {7'd0, byte_ready}, 8'h01);
    idle(2);

    // Scenario 6: reset mid-byte while stuff_err is set, then 0xA5 again.
    strobe(1'b1, 1);
    strobe(1'b0, 1);
    strobe(1'b1, 1);
    check("s6 err before reset", {7'd0, stuff_err}, 8'h01);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    check("s6 reset rx_byte", rx_byte, 8'h00);
    check("s6 reset byte_ready", {7'd0, byte_ready}, 8'h00);
    check("s6 reset stuff_err", {7'd0, stuff_err}, 8'h00);
    n_rst = 1'b1;
    idle(1);
    scenario_a5("s6");

    // Drain: every queued word must have been delivered.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
